// File: rtl/game_tick_sequencer.sv
// Game timing sequencer: one shared rate divider drives a one-cycle step strobe,
// a 0..10 step count and a speed level that rises after ROUNDS count wraps.
module game_tick_sequencer #(
  parameter int DIV_W  = 26,
  parameter int DIV0   = 50_000_000,
  parameter int DIV1   = 25_000_000,
  parameter int DIV2   = 12_500_000,
  parameter int DIV3   = 5_000_000,
  parameter int DIV4   = 2_500_000,
  parameter int ROUNDS = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic       tick,
  output logic [3:0] count,
  output logic [2:0] level,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int RND_W = $clog2(ROUNDS + 1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       count_q, count_d;
  logic [2:0]       level_q, level_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [DIV_W-1:0] reloadFor(input logic [2:0] lvl);
    logic [DIV_W-1:0] r;
    case (lvl)
      3'd0:    r = DIV_W'(DIV0 - 1);
      3'd1:    r = DIV_W'(DIV1 - 1);
      3'd2:    r = DIV_W'(DIV2 - 1);
      3'd3:    r = DIV_W'(DIV3 - 1);
      default: r = DIV_W'(DIV4 - 1);
    endcase
    return r;
  endfunction

  // A PAUSED cycle with pause released behaves as a RUN cycle, so a pause
  // stalls the divider for exactly the number of cycles pause was high.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    count_d  = count_q;
    level_d  = level_q;
    rounds_d = rounds_q;
    tick_d   = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      div_d    = '0;
      count_d  = '0;
      level_d  = '0;
      rounds_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RUN;
            div_d    = reloadFor(3'd0);
            count_d  = '0;
            level_d  = '0;
            rounds_d = '0;
          end
        end
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (div_q != '0) begin
              div_d = div_q - DIV_W'(1);
            end else begin
              tick_d = 1'b1;
              div_d  = reloadFor(level_q);
              if (count_q < 4'd10) begin
                count_d = count_q + 4'd1;
              end else begin
                count_d = '0;
                if (rounds_q != RND_W'(ROUNDS - 1)) begin
                  rounds_d = rounds_q + RND_W'(1);
                end else begin
                  rounds_d = '0;
                  if (level_q < 3'd4) begin
                    level_d = level_q + 3'd1;
                    div_d   = reloadFor(level_q + 3'd1);
                  end else begin
                    state_d = DONE;
                    div_d   = '0;
                  end
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_d = (state_d == RUN) || (state_d == PAUSED);
  assign done_d = (state_d == DONE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      div_q    <= '0;
      count_q  <= '0;
      level_q  <= '0;
      rounds_q <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      count_q  <= count_d;
      level_q  <= level_d;
      rounds_q <= rounds_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Bench for game_tick_sequencer: a table of control vectors plus a tick
// scoreboard that predicts the edge, count and level of every strobe.
module tb_game_tick_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       stop     = 1'b0;
  logic       tick;
  logic [3:0] count;
  logic [2:0] level;
  logic       busy;
  logic       done;

  int testsRun    = 0;
  int testsFailed = 0;
  int edgeCnt     = 0;

  typedef struct {
    int         edgeNo;
    logic [3:0] cnt;
    logic [2:0] lvl;
  } tickExp_t;

  typedef struct {
    string      name;
    logic       st;
    logic       pa;
    logic       sp;
    int         cycles;
    logic [9:0] exp;
  } vec_t;

  tickExp_t expQ[$];
  vec_t     vecs[12];

  int mCount, mLevel, mRounds, nextEdge;
  bit mDone;

  game_tick_sequencer #(
    .DIV_W(4), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(2), .DIV4(1), .ROUNDS(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .start(start),
    .pause(pause),
    .stop(stop),
    .tick(tick),
    .count(count),
    .level(level),
    .busy(busy),
    .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int divOf(input int l);
    case (l)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic vec_t mkVec(input string n, input logic s, input logic p,
                                 input logic t, input int c, input logic [9:0] e);
    vec_t v;
    v.name = n; v.st = s; v.pa = p; v.sp = t; v.cycles = c; v.exp = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic t, input int n);
    start = s; pause = p; stop = t;
    repeat (n) step();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  // Expected strobe: edge number, count and level right after that step.
  task automatic predictTick();
    tickExp_t e;
    if (mCount == 10) begin
      mCount = 0;
      mRounds++;
      if (mRounds == 2) begin
        mRounds = 0;
        if (mLevel == 4) mDone = 1'b1;
        else mLevel++;
      end
    end else begin
      mCount++;
    end
    e.edgeNo = nextEdge;
    e.cnt    = 4'(mCount);
    e.lvl    = 3'(mLevel);
    expQ.push_back(e);
    if (!mDone) nextEdge += divOf(mLevel);
  endtask

  task automatic startRun();
    mCount = 0; mLevel = 0; mRounds = 0; mDone = 1'b0;
    start = 1'b1;
    nextEdge = edgeCnt + 1 + divOf(0);
    step();
    start = 1'b0;
  endtask

  task automatic waitDrain(input int maxEdges);
    int t = 0;
    while (expQ.size() > 0 && t < maxEdges) begin
      step();
      t++;
    end
    checkOutput("tickDrain", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    tickExp_t e;
    forever begin
      @(posedge CLOCK_50);
      edgeCnt++;
      #1;
      if (tick === 1'b1) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedTick: tick at edge %0d, expected no tick", edgeCnt);
        end else begin
          e = expQ.pop_front();
          checkOutput("tickEdge", edgeCnt, e.edgeNo);
          checkOutput("tickCount", count, e.cnt);
          checkOutput("tickLevel", level, e.lvl);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Outputs packed as {tick, busy, done, count, level}.
    vecs[0]  = mkVec("idleHold",     0, 0, 0, 3, 10'b0_0_0_0000_000);
    vecs[1]  = mkVec("pauseInIdle",  0, 1, 0, 2, 10'b0_0_0_0000_000);
    vecs[2]  = mkVec("stopInIdle",   0, 0, 1, 1, 10'b0_0_0_0000_000);
    vecs[3]  = mkVec("startPulse",   1, 0, 0, 1, 10'b0_1_0_0000_000);
    vecs[4]  = mkVec("runShort",     0, 0, 0, 2, 10'b0_1_0_0000_000);
    vecs[5]  = mkVec("pauseHold",    0, 1, 0, 3, 10'b0_1_0_0000_000);
    vecs[6]  = mkVec("stopPaused",   0, 1, 1, 1, 10'b0_0_0_0000_000);
    vecs[7]  = mkVec("idleNoTick",   0, 0, 0, 6, 10'b0_0_0_0000_000);
    vecs[8]  = mkVec("startAgain",   1, 0, 0, 1, 10'b0_1_0_0000_000);
    vecs[9]  = mkVec("startInRun",   1, 0, 0, 2, 10'b0_1_0_0000_000);
    vecs[10] = mkVec("stopRunEarly", 0, 0, 1, 1, 10'b0_0_0_0000_000);
    vecs[11] = mkVec("idleFinal",    0, 0, 0, 5, 10'b0_0_0_0000_000);

    step();
    step();
    checkOutput("resetState", {tick, busy, done, count, level}, 0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].st, vecs[i].pa, vecs[i].sp, vecs[i].cycles);
      checkOutput(vecs[i].name, {tick, busy, done, count, level}, {22'b0, vecs[i].exp});
    end

    startRun();
    repeat (10) predictTick();
    waitDrain(100);
    checkOutput("count10", count, 10);
    checkOutput("level0AtTen", level, 0);
    checkOutput("busyInRun", busy, 1);

    repeat (13) predictTick();
    waitDrain(200);
    checkOutput("level1", level, 1);

    while (!mDone) predictTick();
    waitDrain(400);
    checkOutput("doneFlag", done, 1);
    checkOutput("doneBusy", busy, 0);
    checkOutput("doneLevel", level, 4);
    checkOutput("doneCount", count, 0);
    repeat (3) step();
    checkOutput("doneHold", {busy, done, count, level}, {1'b0, 1'b1, 4'd0, 3'd4});

    startRun();
    checkOutput("restartLevel", level, 0);
    repeat (2) predictTick();
    waitDrain(50);
    checkOutput("restartDone", done, 0);

    step();
    pause = 1'b1;
    repeat (5) begin
      step();
      checkOutput("pauseCount", count, 2);
      checkOutput("pauseBusy", busy, 1);
    end
    pause = 1'b0;
    nextEdge += 5;
    predictTick();
    waitDrain(50);

    repeat (2) predictTick();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    waitDrain(50);
    checkOutput("startIgnoredCount", count, 5);

    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("stopRun", {tick, busy, done, count, level}, 0);

    startRun();
    predictTick();
    waitDrain(50);
    step();
    pause = 1'b1;
    step();
    step();
    checkOutput("pausedBeforeStop", {busy, count}, {1'b1, 4'd1});
    stop = 1'b1;
    step();
    stop = 1'b0;
    pause = 1'b0;
    checkOutput("stopPausedSeq", {tick, busy, done, count, level}, 0);
    repeat (6) step();

    startRun();
    repeat (3) predictTick();
    waitDrain(50);
    step();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("asyncReset", {tick, busy, done, count, level}, 0);
    #1;
    resetn = 1'b1;
    repeat (10) step();
    checkOutput("idleAfterReset", {tick, busy, done, count, level}, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/game_tick_sequencer.md
# game_tick_sequencer

Controls game timing from a single shared rate divider. It produces a one-cycle `tick` strobe and a 0–10 step count at a speed selected by an internal difficulty level. Each time the count wraps, the block counts a round, and after a fixed number of rounds it raises the level to a faster rate. It sits between the game-control FSM (start, pause and stop commands) and the game logic and display, which consume `tick`, `count` and `level`.

## Interface
Parameters:
- `DIV_W`, 26: width of the divider counter; must hold the largest DIVn − 1.
- `DIV0`, 50_000_000: cycles per tick at level 0 (1 Hz at 50 MHz).
- `DIV1`, 25_000_000: cycles per tick at level 1.
- `DIV2`, 12_500_000: cycles per tick at level 2.
- `DIV3`, 5_000_000: cycles per tick at level 3.
- `DIV4`, 2_500_000: cycles per tick at level 4.
- `ROUNDS`, 2: count wraps per level before advancing, ≥ 1.

Ports:
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new run; sampled only in IDLE or DONE.
- `pause`  in  1  level-sensitive hold request.
- `stop`  in  1  synchronous abort to IDLE; highest priority after reset.
- `tick`  out  1  registered one-cycle strobe, one per step.
- `count`  out  4  current step, 0..10.
- `level`  out  3  current speed level, 0..4.
- `busy`  out  1  high in RUN or PAUSED.
- `done`  out  1  high in DONE.

## Operation
- States are IDLE, RUN, PAUSED and DONE. Reset enters IDLE.
- Reset values: `tick`=0, `count`=0, `level`=0, `busy`=0, `done`=0. Internal counters reset to 0.
- State transitions, in priority order:
  - `stop`=1 moves any state to IDLE. It clears `count`, `level` and the round counter, and sets `tick`=0.
  - IDLE or DONE with `start`=1 moves to RUN. It clears `count`, `level` and rounds, and loads the divider with DIV0−1.
  - RUN with `pause`=1 moves to PAUSED. The divider, `count`, `level` and rounds freeze. `tick` is 0 while PAUSED.
  - PAUSED with `pause`=0 moves to RUN. The divider resumes from its held value.
  - `start` in RUN or PAUSED is ignored.
- Divider behaviour in RUN with `pause`=0:
  - If the divider is nonzero, it decrements.
  - If the divider is 0, a step occurs at that edge: `tick`<=1 and the divider reloads with DIV[next level]−1.
- Step rules:
  - If `count` is below 10, `count` increments by 1.
  - If `count` is 10, `count` wraps to 0 and the round counter increments.
- When the round counter would reach ROUNDS:
  - The round counter returns to 0.
  - If `level` is below 4, `level` increments. The reload at the same edge uses the new level's divisor.
  - If `level` is 4, the state moves to DONE and the final `tick` is still emitted. `count` shows 0 and `level` holds at 4 while in DONE.
- A `pause` that arrives in the same cycle the divider is at 0 takes priority, so no step happens. The divider stays at 0 and the step fires on the first RUN cycle after resume.
- Width rule: the divider is DIV_W bits wide, `count` is 4 bits and rounds use clog2(ROUNDS+1) bits. `level` never exceeds 4, so no value ever wraps past its defined range.

## Timing
- The start edge (IDLE→RUN) loads DIVn−1. The first `tick` is asserted DIV0 cycles after that edge.
- `tick` is high for exactly one cycle. `count`, `level` and the state change on the same edge that raises `tick`.
- In steady RUN, the tick period is DIVn cycles at level n. The first tick after a level-up follows DIV[new] cycles later.
- Pause adds exactly the number of paused cycles to the current interval. Cycles are neither lost nor gained.
- `busy` and `done` are registered from the state and change on the same edge as the state.
- Asserting `resetn` low in mid-run forces all outputs to their reset values immediately, without waiting for a clock.

## Test plan
For all scenarios, set DIV0..DIV4 = 4, 3, 2, 2, 1 and ROUNDS = 2.
- Reset, then `start` for one cycle → the first `tick` comes 4 cycles later with `count`=1. Subsequent ticks are every 4 cycles, and after the 10th tick `count`=10.
- Continue from the previous scenario → the 11th tick gives `count`=0 and `level`=0. The 22nd tick gives `count`=0 and `level`=1, and the next tick spacing becomes 3 cycles.
- Run to completion → at level 4, ticks come every cycle. After the last wrap, `done`=1, `busy`=0, `level`=4 and `count`=0. A later `start` restarts with `level`=0 and 4-cycle spacing.
- `pause` for 5 cycles starting 2 cycles after a tick at level 0 → no `tick` during the pause. The next tick arrives 4+5 cycles after the previous one, and `count` is unchanged during the pause.
- `stop` during RUN, and separately during PAUSED → the next edge gives IDLE with `count`=0, `level`=0 and `tick`=0. A `start` pulse in RUN has no effect on the tick schedule.
- Drive `resetn` low between clock edges in the middle of a RUN → all outputs go to 0 asynchronously. With `resetn` high again and no `start`, the block stays idle and no `tick` occurs.
